commit_trace: RTL

Downstream monitor for the single-cycle MIPS core. It captures every architectural write the core commits (GRF write-back and DM store) into a small FIFO of trace records. Records drain over a valid/ready stream to the testbench or a UART dumper, so trace output no longer depends on `$display` inside GRF/DM. It sits beside the core top-level and consumes the same signals the core drives into its GRF and DM instances.

---
 rtl/trace_pkg.sv | 15 +
 rtl/trace_ram.sv | 29 ++
 rtl/commit_trace.sv | 102 ++++++++++
 3 files changed

// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - record layout and kind constants for the commit trace
package trace_pkg;

    localparam logic KIND_GRF = 1'b0;
    localparam logic KIND_DM  = 1'b1;
    localparam int   REC_W    = 97;

    typedef struct packed {
        logic        kind;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
    } trace_rec_t;

endpackage

// File: rtl/trace_ram.sv
// rtl/trace_ram.sv - trace record storage, two write ports and one combinational read port
module trace_ram
    import trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we0,
    input  logic [AW-1:0] waddr0,
    input  trace_rec_t    wdata0,
    input  logic          we1,
    input  logic [AW-1:0] waddr1,
    input  trace_rec_t    wdata1,
    input  logic [AW-1:0] raddr,
    output trace_rec_t    rdata
);

    // Contents are never reset; the controller masks the read port while empty.
    trace_rec_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we0) mem[waddr0] <= wdata0;
        if (we1) mem[waddr1] <= wdata1;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/commit_trace.sv
// rtl/commit_trace.sv - captures GRF write-backs and DM stores into a drained record FIFO
module commit_trace
    import trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             grf_we,
    input  logic [31:0]      grf_pc,
    input  logic [4:0]       grf_addr,
    input  logic [31:0]      grf_data,
    input  logic             dm_we,
    input  logic [31:0]      dm_pc,
    input  logic [31:0]      dm_addr,
    input  logic [31:0]      dm_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_kind,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_addr,
    output logic [31:0]      out_data,
    output logic             full,
    output logic [CNT_W-1:0] drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 2;

    logic [AW:0]      count_q, count_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] drop_q, drop_d;

    logic          grf_cand, dm_cand, pop, accept;
    logic [1:0]    n_req, n_push;
    logic [FW-1:0] free;
    logic [AW-1:0] dm_slot;
    trace_rec_t    grf_rec, dm_rec, head_rec;

    assign out_valid = (count_q != '0);
    assign full      = (count_q == (AW+1)'(DEPTH));
    assign drop_cnt  = drop_q;

    always_comb begin
        grf_cand = grf_we && (grf_addr != 5'd0);
        dm_cand  = dm_we;
        n_req    = {1'b0, grf_cand} + {1'b0, dm_cand};
        pop      = out_valid && out_ready;
        // A same-cycle pop releases its slot to this cycle's pushes.
        free     = FW'(DEPTH) - FW'(count_q) + FW'(pop);
        accept   = (FW'(n_req) <= free);
        n_push   = accept ? n_req : 2'd0;

        // GRF always takes the lower slot so it drains first.
        dm_slot  = wr_ptr_q + AW'(grf_cand);
        grf_rec  = '{kind: KIND_GRF, pc: grf_pc, addr: {27'd0, grf_addr}, data: grf_data};
        dm_rec   = '{kind: KIND_DM, pc: dm_pc, addr: dm_addr, data: dm_data};

        count_d  = count_q + (AW+1)'(n_push) - (AW+1)'(pop);
        wr_ptr_d = wr_ptr_q + AW'(n_push);
        rd_ptr_d = rd_ptr_q + AW'(pop);

        drop_d = drop_q;
        if (!accept && (drop_q != '1)) begin
            drop_d = drop_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            drop_q   <= '0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            drop_q   <= drop_d;
        end
    end

    trace_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk    (clk),
        .we0    (!reset && accept && grf_cand),
        .waddr0 (wr_ptr_q),
        .wdata0 (grf_rec),
        .we1    (!reset && accept && dm_cand),
        .waddr1 (dm_slot),
        .wdata1 (dm_rec),
        .raddr  (rd_ptr_q),
        .rdata  (head_rec)
    );

    assign {out_kind, out_pc, out_addr, out_data} = out_valid ? head_rec : '0;

endmodule
